// File: rtl/mute_pass_ctrl.sv
// Multi-pass sequencer for the convolution CPU. It runs pass_req 5x5 passes back to back,
// shrinking the image by KSIZE-1 after each pass, and flags undersize, timeout and size-mismatch faults.
module mute_pass_ctrl #(
  parameter int KSIZE       = 5,
  parameter int CPU_RST_CYC = 4,
  parameter int TIMEOUT     = 1048576,
  parameter int TW          = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  pass_req,
  input  logic [16:0] row_in,
  input  logic [16:0] col_in,
  input  logic        end_cpu,
  input  logic [16:0] next_row,
  input  logic [16:0] next_column,
  output logic        cpu_reset,
  output logic [16:0] cpu_row,
  output logic [16:0] cpu_column,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  passes_done,
  output logic [16:0] final_row,
  output logic [16:0] final_column
);

  localparam int RW = (CPU_RST_CYC > 1) ? $clog2(CPU_RST_CYC) : 1;
  localparam logic [16:0]   KMIN     = 17'(KSIZE);
  localparam logic [16:0]   SHRINK   = 17'(KSIZE - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(CPU_RST_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, RST_CPU, ARM, RUN, ADVANCE, DONE, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [16:0]   cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [3:0]    req_q, req_d, passes_q, passes_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          end_seen_q, end_seen_d;
  logic          cpu_reset_q, cpu_reset_d, busy_q, busy_d, done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [16:0]   final_row_q, final_row_d, final_col_q, final_col_d;
  logic [3:0]    passes_inc;

  assign passes_inc = passes_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    req_d       = req_q;
    passes_d    = passes_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_d       = tmo_q;
    end_seen_d  = end_seen_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    final_row_d = final_row_q;
    final_col_d = final_col_q;
    case (state_q)
      IDLE: if (start) begin
        cur_row_d  = row_in;
        cur_col_d  = col_in;
        req_d      = pass_req;
        passes_d   = 4'd0;
        error_d    = 1'b0;
        err_code_d = 2'b00;
        state_d    = (pass_req == 4'd0) ? DONE : CHECK;
      end
      CHECK: begin
        if (cur_row_q < KMIN || cur_col_q < KMIN) begin
          state_d    = ERR;
          err_code_d = 2'b01;
        end else begin
          state_d   = RST_CPU;
          rst_cnt_d = RST_LOAD;
        end
      end
      RST_CPU: begin
        tmo_d = '0;
        if (rst_cnt_q == '0) state_d = ARM;
        else                 rst_cnt_d = rst_cnt_q - 1'b1;
      end
      ARM: begin
        tmo_d      = tmo_q + 1'b1;
        end_seen_d = 1'b0;
        if (tmo_q == TMO_LAST) begin
          state_d    = ERR;
          err_code_d = 2'b10;
        end else if (!end_cpu) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // end_cpu must be seen high twice in a row; a single-cycle blip is ignored
        tmo_d      = tmo_q + 1'b1;
        end_seen_d = end_cpu;
        if (tmo_q == TMO_LAST) begin
          state_d    = ERR;
          err_code_d = 2'b10;
        end else if (end_cpu && end_seen_q) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if (next_row != cur_row_q - SHRINK || next_column != cur_col_q - SHRINK) begin
          state_d    = ERR;
          err_code_d = 2'b11;
        end else begin
          cur_row_d = next_row;
          cur_col_d = next_column;
          passes_d  = passes_inc;
          state_d   = (passes_inc == req_q) ? DONE : CHECK;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered off the next state so they line up with the state they describe
    cpu_reset_d = (state_d == ARM) || (state_d == RUN);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    if (state_d == ERR) error_d = 1'b1;
    if (state_d == DONE) begin
      final_row_d = cur_row_d;
      final_col_d = cur_col_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      req_q       <= '0;
      passes_q    <= '0;
      rst_cnt_q   <= '0;
      tmo_q       <= '0;
      end_seen_q  <= 1'b0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'b00;
      final_row_q <= '0;
      final_col_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      req_q       <= req_d;
      passes_q    <= passes_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_q       <= tmo_d;
      end_seen_q  <= end_seen_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      final_row_q <= final_row_d;
      final_col_q <= final_col_d;
    end
  end

  // The size only changes on the ADVANCE exit, when cpu_reset is already low
  assign cpu_row      = cur_row_q;
  assign cpu_column   = cur_col_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign passes_done  = passes_q;
  assign final_row    = final_row_q;
  assign final_column = final_col_q;

endmodule

// File: tb/tb_mute_pass_ctrl.sv
// Directed bench for mute_pass_ctrl with a small behavioural CPU that reacts to cpu_reset.
module tb_mute_pass_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  pass_req = '0;
  logic [16:0] row_in = '0, col_in = '0;
  logic        end_cpu = 1'b1;
  logic [16:0] next_row = '0, next_column = '0;
  logic        cpu_reset, busy, done, error;
  logic [16:0] cpu_row, cpu_column, final_row, final_column;
  logic [1:0]  err_code;
  logic [3:0]  passes_done;

  int n_chk = 0, n_err = 0;
  int cpu_mode = 0;
  int ccnt = 0;
  int n_done, first_arm, err_cyc, err_at1;
  logic [16:0] arm_rows[$];

  mute_pass_ctrl #(.KSIZE(5), .CPU_RST_CYC(4), .TIMEOUT(64), .TW(7)) dut (
    .clk(clk), .reset(reset), .start(start), .pass_req(pass_req),
    .row_in(row_in), .col_in(col_in), .end_cpu(end_cpu),
    .next_row(next_row), .next_column(next_column),
    .cpu_reset(cpu_reset), .cpu_row(cpu_row), .cpu_column(cpu_column),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .passes_done(passes_done), .final_row(final_row), .final_column(final_column)
  );

  always #5 clk = ~clk;

  // CPU model: mode 0 normal pass, 1 end_cpu stuck high, 2 one-cycle blip then wrong row count
  always @(negedge clk) begin
    if (!cpu_reset) begin
      ccnt = 0;
      end_cpu = 1'b1;
    end else begin
      ccnt = ccnt + 1;
      case (cpu_mode)
        0:       end_cpu = !(ccnt >= 3 && ccnt < 53);
        1:       end_cpu = 1'b1;
        default: end_cpu = !((ccnt >= 3 && ccnt < 20) || (ccnt >= 21 && ccnt < 40));
      endcase
    end
    next_row    = cpu_row - ((cpu_mode == 2) ? 17'd5 : 17'd4);
    next_column = cpu_column - 17'd4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Pulse start, then follow the job cycle by cycle (cycle 1 = first cycle after start sampled)
  task automatic run_job(input logic [16:0] r, input logic [16:0] c, input logic [3:0] p);
    logic prev;
    row_in = r; col_in = c; pass_req = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; first_arm = -1; err_cyc = -1; err_at1 = error;
    arm_rows.delete();
    prev = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (cpu_reset && !prev) begin
        arm_rows.push_back(cpu_row);
        if (first_arm < 0) first_arm = cyc;
      end
      prev = cpu_reset;
      if (done) n_done++;
      if (error && err_cyc < 0) err_cyc = cyc;
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("job_ended", busy, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cpu_reset", cpu_reset, 0);
    chk("rst_done", done, 0);
    chk("rst_error", {error, err_code}, 0);
    chk("rst_final", {final_row, final_column}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // 1: two passes 32 -> 28 -> 24
    cpu_mode = 0;
    run_job(17'd32, 17'd32, 4'd2);
    chk("t1_arm_count", arm_rows.size(), 2);
    chk("t1_row_pass1", (arm_rows.size() > 0) ? arm_rows[0] : 17'h1ffff, 32);
    chk("t1_row_pass2", (arm_rows.size() > 1) ? arm_rows[1] : 17'h1ffff, 28);
    chk("t1_arm_latency", first_arm, 6);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_final_row", final_row, 24);
    chk("t1_final_col", final_column, 24);
    chk("t1_passes", passes_done, 2);
    chk("t1_error", error, 0);
    chk("t1_cpu_reset", cpu_reset, 0);

    // 2: zero passes goes straight to DONE
    run_job(17'd40, 17'd40, 4'd0);
    chk("t2_done_pulses", n_done, 1);
    chk("t2_final", {final_row, final_column}, {17'd40, 17'd40});
    chk("t2_never_armed", arm_rows.size(), 0);
    chk("t2_passes", passes_done, 0);

    // 3: 7 rows survive one pass then fail the size check
    run_job(17'd7, 17'd32, 4'd2);
    chk("t3_arm_count", arm_rows.size(), 1);
    chk("t3_error", error, 1);
    chk("t3_err_code", err_code, 2'b01);
    chk("t3_passes", passes_done, 1);
    chk("t3_no_done", n_done, 0);
    chk("t3_final_held", final_row, 40);

    // 4: end_cpu stuck high times out 64 cycles after ARM entry
    cpu_mode = 1;
    run_job(17'd32, 17'd32, 4'd1);
    chk("t4_error_cleared", err_at1, 0);
    chk("t4_err_code", err_code, 2'b10);
    chk("t4_tmo_cycles", err_cyc - first_arm, 64);
    chk("t4_cpu_reset", cpu_reset, 0);
    chk("t4_error", error, 1);

    // 5: blip ignored, then the CPU reports 27 instead of 28
    cpu_mode = 2;
    run_job(17'd32, 17'd32, 4'd1);
    chk("t5_err_code", err_code, 2'b11);
    chk("t5_err_cycle", err_cyc, 48);
    chk("t5_passes", passes_done, 0);

    // 6: start while busy ignored, then reset mid-RUN
    cpu_mode = 0;
    row_in = 17'd32; col_in = 17'd32; pass_req = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    row_in = 17'd100; col_in = 17'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_no_relatch", cpu_row, 32);
    chk("t6_running", {busy, cpu_reset}, 2'b11);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cpu_reset", cpu_reset, 0);
    chk("t6_rst_cpu_size", {cpu_row, cpu_column}, 0);
    chk("t6_rst_flags", {done, error, err_code, passes_done}, 0);
    chk("t6_rst_final", {final_row, final_column}, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
